// File: rtl/facto_core_param.sv
`timescale 1ns/1ps
// facto_core_param: memory-mapped factorial accelerator.
// The CPU programs OPERAND = N and writes START. The core then computes N! into a
// 2*DATA_W accumulator, using a radix-2 shift-add multiplier that handles one
// operand bit per cycle. When the result is ready it raises done, and interrupt
// follows if INTR_EN is set. Bits of N! above RES_W are dropped: acc keeps the
// result modulo 2^RES_W and the sticky overflow flag records that bits were lost.
// Assumes DATA_W > OPND_W >= 2.
module facto_core_param #(
    parameter int          DATA_W    = 64,
    parameter int          OPND_W    = 32,
    parameter logic [7:0]  BASE_ADDR = 8'h70
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [15:0]       s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              interrupt
);

    localparam int RES_W  = 2 * DATA_W;
    localparam int PROD_W = RES_W + OPND_W;
    localparam int CNT_W  = $clog2(OPND_W) + 1;

    localparam logic [4:0] IDX_START  = 5'd0;
    localparam logic [4:0] IDX_CLEAR  = 5'd1;
    localparam logic [4:0] IDX_STATUS = 5'd2;
    localparam logic [4:0] IDX_INTR   = 5'd3;
    localparam logic [4:0] IDX_OPND   = 5'd4;
    localparam logic [4:0] IDX_RESH   = 5'd5;
    localparam logic [4:0] IDX_RESL   = 5'd6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MUL  = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              state_q;
    logic [RES_W-1:0]    acc_q;
    logic [PROD_W-1:0]   prod_q;      // {partial sum, remaining multiplier bits}
    logic [OPND_W-1:0]   k_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                overflow_q;
    logic                done_q;
    logic                busy_q;
    logic                intr_en_q;
    logic [OPND_W-1:0]   operand_q;
    logic [DATA_W-1:0]   s_dout_q;

    logic                hit_s;
    logic [4:0]          idx_s;
    logic                wr_start_s;
    logic                wr_clear_s;
    logic                wr_intr_s;
    logic                wr_opnd_s;
    logic                rd_en_s;
    logic                opnd_small_s;
    logic [RES_W:0]      add_d;
    logic [PROD_W-1:0]   prod_d;
    logic [OPND_W-1:0]   k_dec_d;
    logic [DATA_W-1:0]   rdata_d;
    logic                unused_bits;

    // The address offset bits and the write data above the operand width are not used.
    assign unused_bits = ^{s_addr[2:0], s_din[DATA_W-1:OPND_W]};

    // Decode bus accesses into per-register strobes.
    always_comb begin
        hit_s        = s_sel && (s_addr[15:8] == BASE_ADDR);
        idx_s        = s_addr[7:3];
        wr_start_s   = hit_s && s_wr && (idx_s == IDX_START) && s_din[0];
        wr_clear_s   = hit_s && s_wr && (idx_s == IDX_CLEAR) && s_din[0];
        wr_intr_s    = hit_s && s_wr && (idx_s == IDX_INTR);
        wr_opnd_s    = hit_s && s_wr && (idx_s == IDX_OPND);
        rd_en_s      = hit_s && !s_wr;
        opnd_small_s = (operand_q < OPND_W'(2));
    end

    // One shift-add step: add acc when the current multiplier LSB is set, then shift right.
    always_comb begin
        add_d   = {1'b0, prod_q[PROD_W-1:OPND_W]}
                + (prod_q[0] ? {1'b0, acc_q} : {(RES_W+1){1'b0}});
        prod_d  = {add_d, prod_q[OPND_W-1:1]};
        k_dec_d = k_q - OPND_W'(1);
    end

    // Read-data multiplexer; unmapped indices return zero.
    always_comb begin
        rdata_d = {DATA_W{1'b0}};
        case (idx_s)
            IDX_STATUS: rdata_d = DATA_W'({overflow_q, busy_q, done_q});
            IDX_INTR:   rdata_d = DATA_W'(intr_en_q);
            IDX_OPND:   rdata_d = DATA_W'(operand_q);
            IDX_RESH:   rdata_d = acc_q[RES_W-1:DATA_W];
            IDX_RESL:   rdata_d = acc_q[DATA_W-1:0];
            default:    rdata_d = {DATA_W{1'b0}};
        endcase
    end

    // Registered read port with one-cycle latency; idle cycles drive zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_dout_q <= {DATA_W{1'b0}};
        end else if (rd_en_s) begin
            s_dout_q <= rdata_d;
        end else begin
            s_dout_q <= {DATA_W{1'b0}};
        end
    end

    // Control FSM plus the configuration registers it owns.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= RES_W'(1);
            prod_q     <= {PROD_W{1'b0}};
            k_q        <= {OPND_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            intr_en_q  <= 1'b0;
            operand_q  <= {OPND_W{1'b0}};
        end else begin
            if (wr_intr_s) begin
                intr_en_q <= s_din[0];
            end
            if (wr_opnd_s && !busy_q) begin
                operand_q <= s_din[OPND_W-1:0];
            end

            if (wr_clear_s) begin
                state_q    <= ST_IDLE;
                acc_q      <= RES_W'(1);
                done_q     <= 1'b0;
                overflow_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (wr_start_s) begin
                            if (opnd_small_s) begin
                                // 0! and 1! are 1; done follows from DONE one cycle later
                                state_q    <= ST_DONE;
                                acc_q      <= RES_W'(1);
                                overflow_q <= 1'b0;
                            end else begin
                                state_q <= ST_LOAD;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        acc_q      <= RES_W'(1);
                        k_q        <= operand_q;
                        prod_q     <= PROD_W'(operand_q);
                        overflow_q <= 1'b0;
                        cnt_q      <= {CNT_W{1'b0}};
                        state_q    <= ST_MUL;
                    end
                    ST_MUL: begin
                        prod_q <= prod_d;
                        if (cnt_q == CNT_W'(OPND_W - 1)) begin
                            cnt_q   <= {CNT_W{1'b0}};
                            state_q <= ST_NEXT;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_NEXT: begin
                        acc_q      <= prod_q[RES_W-1:0];
                        overflow_q <= overflow_q | (|prod_q[PROD_W-1:RES_W]);
                        k_q        <= k_dec_d;
                        prod_q     <= PROD_W'(k_dec_d);
                        if (k_q == OPND_W'(2)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_MUL;
                        end
                    end
                    ST_DONE: begin
                        done_q <= 1'b1;
                        if (wr_start_s) begin
                            done_q <= 1'b0;
                            if (opnd_small_s) begin
                                // restart with a trivial operand: no multiply pass needed
                                acc_q      <= RES_W'(1);
                                overflow_q <= 1'b0;
                            end else begin
                                state_q <= ST_LOAD;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_dout    = s_dout_q;
    assign interrupt = done_q & intr_en_q;

endmodule

// File: tb/tb_facto_core_param.sv
`timescale 1ns/1ps
// Self-checking bench for facto_core_param: table vectors, hand-written corner
// sequences and randomized operands compared against an arithmetic factorial model.
module tb_facto_core_param;

    localparam int         DATA_W = 64;
    localparam int         OPND_W = 32;
    localparam logic [7:0] BASE   = 8'h70;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_sel;
    logic              s_wr;
    logic [15:0]       s_addr;
    logic [DATA_W-1:0] s_din;
    logic [DATA_W-1:0] s_dout;
    logic              interrupt;

    int checks = 0;
    int errors = 0;

    facto_core_param #(.DATA_W(DATA_W), .OPND_W(OPND_W), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_sel     (s_sel),
        .s_wr      (s_wr),
        .s_addr    (s_addr),
        .s_din     (s_din),
        .s_dout    (s_dout),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        int          n;
        logic [63:0] exp_h;
        logic [63:0] exp_l;
        logic        use_const;
        logic [63:0] exp_status;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // True N! reduced mod 2^128, plus whether any bit above 2^128 was ever lost.
    task automatic fact_model(input int n, output logic [127:0] r, output logic o);
        logic [255:0] p;
        r = 128'd1;
        o = 1'b0;
        for (int i = 2; i <= n; i++) begin
            p = {128'd0, r} * 256'(i);
            if (p[255:128] != 128'd0) o = 1'b1;
            r = p[127:0];
        end
    endtask

    function automatic int exp_latency(input int n);
        return (n < 2) ? 1 : 1 + (n - 1) * (OPND_W + 1);
    endfunction

    task automatic bus_wr(input logic [4:0] idx, input logic [63:0] d);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = {BASE, idx, 3'b000}; s_din = d;
        @(posedge clk);
        #1;
        s_sel = 1'b0; s_wr = 1'b0; s_din = 64'd0;
    endtask

    task automatic bus_rd_addr(input logic [15:0] addr, output logic [63:0] d);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = addr;
        @(posedge clk);
        #1;
        d = s_dout;
        s_sel = 1'b0;
    endtask

    task automatic bus_rd(input logic [4:0] idx, output logic [63:0] d);
        bus_rd_addr({BASE, idx, 3'b000}, d);
    endtask

    // Count edges after the START edge until interrupt rises; -1 if budget expires.
    task automatic wait_irq(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 3000; c++) begin
            @(posedge clk);
            #1;
            if (interrupt) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input int n);
        logic [127:0] r;
        logic         o;
        logic [63:0]  d;
        int           cyc;
        fact_model(n, r, o);
        bus_wr(5'd0, 64'd1);
        wait_irq(cyc);
        chk({tag, "_latency"}, 128'(cyc), 128'(exp_latency(n)));
        bus_rd(5'd2, d);
        chk({tag, "_status"}, 128'(d), 128'({o, 1'b0, 1'b1}));
        bus_rd(5'd5, d);
        chk({tag, "_res_h"}, 128'(d), 128'(r[127:64]));
        bus_rd(5'd6, d);
        chk({tag, "_res_l"}, 128'(d), 128'(r[63:0]));
    endtask

    initial begin
        logic [127:0] r;
        logic         o;
        logic [63:0]  d;
        logic [63:0]  hi;
        int           cyc;
        int           n;

        vecs[0] = '{5,  64'h0, 64'h78,               1'b1, 64'h1};
        vecs[1] = '{0,  64'h0, 64'h1,                1'b1, 64'h1};
        vecs[2] = '{1,  64'h0, 64'h1,                1'b1, 64'h1};
        vecs[3] = '{21, 64'h2, 64'hC5077D36B8C40000, 1'b1, 64'h1};
        vecs[4] = '{34, 64'h0, 64'h0,                1'b0, 64'h1};
        vecs[5] = '{35, 64'h0, 64'h0,                1'b0, 64'h5};

        reset = 1'b1; s_sel = 1'b0; s_wr = 1'b0; s_addr = 16'd0; s_din = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        chk("reset_dout", 128'(s_dout), 128'd0);
        chk("reset_irq", 128'(interrupt), 128'd0);
        bus_rd(5'd2, d); chk("reset_status", 128'(d), 128'd0);
        bus_rd(5'd6, d); chk("reset_res_l", 128'(d), 128'd1);
        bus_rd(5'd5, d); chk("reset_res_h", 128'(d), 128'd0);
        bus_rd(5'd3, d); chk("reset_intr_en", 128'(d), 128'd0);
        bus_rd(5'd4, d); chk("reset_operand", 128'(d), 128'd0);

        bus_wr(5'd3, 64'd1);
        bus_rd(5'd3, d); chk("intr_en_rb", 128'(d), 128'd1);

        // table-driven vectors
        for (int i = 0; i < 6; i++) begin
            fact_model(vecs[i].n, r, o);
            bus_wr(5'd1, 64'd1);
            bus_wr(5'd4, 64'(vecs[i].n));
            bus_wr(5'd0, 64'd1);
            wait_irq(cyc);
            chk($sformatf("vec%0d_latency", i), 128'(cyc), 128'(exp_latency(vecs[i].n)));
            bus_rd(5'd2, d);
            chk($sformatf("vec%0d_status", i), 128'(d), 128'(vecs[i].exp_status));
            bus_rd(5'd5, d);
            chk($sformatf("vec%0d_res_h", i), 128'(d),
                vecs[i].use_const ? 128'(vecs[i].exp_h) : 128'(r[127:64]));
            bus_rd(5'd6, d);
            chk($sformatf("vec%0d_res_l", i), 128'(d),
                vecs[i].use_const ? 128'(vecs[i].exp_l) : 128'(r[63:0]));
        end

        // restart from DONE without CLEAR: done must drop at the START edge
        bus_wr(5'd4, 64'd6);
        bus_wr(5'd0, 64'd1);
        chk("restart_done_drop", 128'(interrupt), 128'd0);
        wait_irq(cyc);
        chk("restart_latency", 128'(cyc), 128'(exp_latency(6)));
        bus_rd(5'd2, d); chk("restart_status", 128'(d), 128'h1);
        bus_rd(5'd6, d); chk("restart_res_l", 128'(d), 128'd720);

        // INTR_EN = 0 drops interrupt right after the write edge
        chk("irq_before_disable", 128'(interrupt), 128'd1);
        bus_wr(5'd3, 64'd0);
        chk("irq_after_disable", 128'(interrupt), 128'd0);
        bus_wr(5'd3, 64'd1);

        // unmapped index 7 and wrong base read zero
        bus_rd(5'd6, d);
        bus_rd(5'd7, d); chk("idx7_read", 128'(d), 128'd0);
        bus_rd_addr({8'h71, 5'd6, 3'b000}, d); chk("wrong_base_read", 128'(d), 128'd0);

        // abort: writes while busy are ignored, CLEAR returns to idle
        bus_wr(5'd1, 64'd1);
        bus_wr(5'd4, 64'd20);
        bus_wr(5'd0, 64'd1);
        repeat (50) @(posedge clk);
        bus_wr(5'd4, 64'd3);
        bus_wr(5'd0, 64'd1);
        bus_rd(5'd2, d); chk("abort_busy_status", 128'(d), 128'h2);
        bus_rd(5'd4, d); chk("abort_operand_kept", 128'(d), 128'd20);
        bus_wr(5'd1, 64'd1);
        bus_rd(5'd2, d); chk("abort_clear_status", 128'(d), 128'd0);
        bus_rd(5'd6, d); chk("abort_clear_res_l", 128'(d), 128'd1);
        bus_wr(5'd4, 64'd3);
        run_and_check("after_abort", 3);

        // synchronous reset in the middle of a computation
        bus_wr(5'd1, 64'd1);
        bus_wr(5'd4, 64'd10);
        bus_wr(5'd0, 64'd1);
        repeat (100) @(posedge clk);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = {BASE, 5'd3, 3'b000};
        @(posedge clk);
        #1;
        chk("prereset_dout", 128'(s_dout), 128'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_dout", 128'(s_dout), 128'd0);
        chk("midreset_irq", 128'(interrupt), 128'd0);
        s_sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bus_rd(5'd2, d); chk("midreset_status", 128'(d), 128'd0);
        bus_rd(5'd6, d); chk("midreset_res_l", 128'(d), 128'd1);
        bus_rd(5'd3, d); chk("midreset_intr_en", 128'(d), 128'd0);
        bus_rd(5'd4, d); chk("midreset_operand", 128'(d), 128'd0);

        // randomized operands with junk in the upper write-data bits
        bus_wr(5'd3, 64'd1);
        for (int i = 0; i < 8; i++) begin
            n  = int'($urandom_range(0, 36));
            hi = {$urandom, 32'd0};
            if ($urandom_range(0, 1) == 1) bus_wr(5'd1, 64'd1);
            bus_wr(5'd4, hi | 64'(n));
            bus_rd(5'd4, d);
            chk($sformatf("rand%0d_operand", i), 128'(d), 128'(n));
            run_and_check($sformatf("rand%0d_n%0d", i, n), n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/facto_core_param.md
Name: facto_core_param

Overview:
- Parametrised factorial accelerator: bus-slave register file plus an internal radix-2 shift-add multiplier. Computes N! for a programmed operand N.
- Accumulates into a 2×DATA_W result, with a sticky overflow flag, busy/done status, interrupt gating and restart-from-DONE.
- Sits on the system slave bus as a memory-mapped peripheral. Raises `interrupt` to the CPU/interrupt controller on completion.

Parameters:
- DATA_W, 64: bus data width. Result accumulator width RES_W = 2*DATA_W is derived, not a parameter.
- OPND_W, 32: operand width; the multiplier runs 1 bit per cycle, OPND_W cycles per multiply.
- BASE_ADDR, 8'h70: block is selected when s_addr[15:8] == BASE_ADDR.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- s_sel, input, 1: slave select.
- s_wr, input, 1: 1 = write, 0 = read.
- s_addr, input, 16: byte address; the register index is s_addr[7:3].
- s_din, input, DATA_W: write data.
- s_dout, output, DATA_W: registered read data.
- interrupt, output, 1: done & intr_en.

Behaviour:
- Register map (index = s_addr[7:3]); unmapped indices read 0 and ignore writes:
  - 0 OP_START, W: bit0=1 starts a computation.
  - 1 OP_CLEAR, W: bit0=1 aborts and clears.
  - 2 STATUS, R: bit0 done, bit1 busy, bit2 overflow.
  - 3 INTR_EN, RW: bit0.
  - 4 OPERAND, RW: low OPND_W bits; upper bits read 0.
  - 5 RESULT_H, R: acc[RES_W-1:DATA_W].
  - 6 RESULT_L, R: acc[DATA_W-1:0].
- Write access: takes effect on the clk edge where s_sel & s_wr & address match.
- Read access: s_dout is loaded on the clk edge where s_sel & ~s_wr & address match, giving 1-cycle read latency; otherwise s_dout <= 0.
- Reset values: state IDLE, acc = 1, overflow = 0, done = 0, busy = 0, intr_en = 0, operand = 0, s_dout = 0, interrupt = 0.
- FSM states: IDLE, LOAD, MUL, NEXT, DONE.
  - IDLE: on START, if operand ≤ 1, go to DONE with acc = 1; else go to LOAD.
  - LOAD: acc <= 1, k <= operand, overflow <= 0, bit counter <= 0 → MUL.
  - MUL: shift-add acc×k, one multiplier bit per cycle, for exactly OPND_W cycles → NEXT. The product is RES_W+OPND_W bits wide.
  - NEXT: acc <= product[RES_W-1:0]; overflow |= |product[RES_W+OPND_W-1:RES_W]; k <= k-1. If k == 2 → DONE, else → MUL.
  - DONE: done = 1 and hold. START → LOAD with done cleared. CLEAR → IDLE.
- Latency: for N ≥ 2, done is set (STATUS.bit0 = 1) exactly 1 + (N-1)*(OPND_W+1) cycles after the START write edge. For N ≤ 1, done is set 1 cycle after.
- busy = 1 in LOAD, MUL and NEXT.
- Writes to START or OPERAND while busy are ignored.
- CLEAR in any state: → IDLE with acc = 1, done = 0, overflow = 0, busy = 0. operand and intr_en are kept.
- Reset asserted mid-operation: all registers return to their reset values on that edge.
- Overflow: sticky for the current computation; acc holds the modulo-2^RES_W result.
- interrupt: combinational AND of the done and intr_en registers. Writing INTR_EN = 0 deasserts it on the next cycle.

Test Plan:
- Write OPERAND = 5, INTR_EN = 1, START = 1:
  - interrupt rises 1 + 4*33 = 133 cycles after the START edge.
  - RESULT_H = 0, RESULT_L = 0x78, STATUS = 0x1.
- OPERAND = 0, then repeat with OPERAND = 1; START each time:
  - done 1 cycle after START.
  - RESULT_L = 1, RESULT_H = 0.
- OPERAND = 21, START:
  - RESULT_H = 0x2, RESULT_L = 0xC5077D36B8C40000, overflow = 0.
- Boundary check:
  - OPERAND = 34 → overflow = 0.
  - OPERAND = 35 → STATUS = 0x5 (done + overflow).
- Abort and ignored writes: start N = 20; mid-MUL, write OPERAND = 3 and START.
  - Both writes are ignored; STATUS = 0x2.
  - Then CLEAR → STATUS = 0, RESULT_L = 1 next cycle.
  - A new START computes 3! = 6.
- In DONE, issue START without CLEAR (restart): recomputes, done drops during busy.
- Sync reset mid-computation: all outputs return to reset values on the reset edge.
- Reading index 7 returns 0.
